aes_ctr_controller: RTL
=======================

AES_CTR_CONTROLLER -- requirements
Module: aes_ctr_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the Block_Count output.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port IV_In  input  128  initial counter block.
REQ-005 SHALL have port IV_Load  input  1  load IV_In into the counter register.
REQ-006 SHALL have port Key_Valid  input  1  core holds an expanded encryption key.
REQ-007 SHALL have port Data_In  input  128  plaintext or ciphertext block.
REQ-008 SHALL have port Data_Valid  input  1  Data_In valid.
REQ-009 SHALL have port Data_Ready  output  1  block accepts Data_In.
REQ-010 SHALL have port Enc_Block  output  128  counter block driven to the core Plaintext_In.
REQ-011 SHALL have port Enc_Start  output  1  one-cycle start pulse to the core.
REQ-012 SHALL have port Enc_Fin  input  1  core finish flag.
REQ-013 SHALL have port Keystream_In  input  128  core Ciphertext_Out.
REQ-014 SHALL have port Data_Out  output  128  Data_In XOR keystream.
REQ-015 SHALL have port Out_Valid  output  1  Data_Out valid.
REQ-016 SHALL have port Out_Ready  input  1  downstream accepts Data_Out.
REQ-017 SHALL have port Block_Count  output  CNT_W  blocks completed since the last IV_Load.
REQ-018 SHALL have port Busy  output  1  high in every state except IDLE and READY.

Function
REQ-019 SHALL implement the states IDLE, READY, START, WAIT and OUTPUT.
REQ-020 SHALL move from IDLE to READY on IV_Load; IV_Load in READY SHALL reload the counter and clear Block_Count; IV_Load in START, WAIT or OUTPUT SHALL be ignored.
REQ-021 SHALL assert Data_Ready only in READY with Key_Valid=1; on Data_Valid&Data_Ready it SHALL register Data_In and go to START.
REQ-022 SHALL assert Enc_Start for exactly one cycle in START, with Enc_Block stable, then go to WAIT.
REQ-023 SHALL drive Enc_Block from the counter register and hold it constant from START until WAIT exits.
REQ-024 SHALL register Enc_Fin every cycle; in WAIT a registered 0->1 transition of Enc_Fin SHALL be completion, and a level already high on WAIT entry SHALL NOT count.
REQ-025 On completion it SHALL register Data_Out = data_reg XOR Keystream_In, increment the counter, increment Block_Count, and go to OUTPUT.
REQ-026 SHALL increment the counter as a full 128-bit unsigned value mod 2^128 (all-ones wraps to zero); Block_Count SHALL wrap mod 2^CNT_W.
REQ-027 SHALL hold Out_Valid high with Data_Out stable in OUTPUT until Out_Ready=1, then go to READY.
REQ-028 Minimum latency from data acceptance to Out_Valid SHALL be 2 cycles plus the core latency.
REQ-029 Key_Valid falling during START, WAIT or OUTPUT SHALL NOT abort the block in flight; it SHALL block the next acceptance only.

Reset
REQ-030 RST SHALL force IDLE, counter=0, data_reg=0, Data_Out=0, Block_Count=0 and the registered Enc_Fin=0 at any time, including mid-WAIT.
REQ-031 During reset Data_Ready, Enc_Start, Out_Valid and Busy SHALL be 0 and Enc_Block SHALL be 0.
REQ-032 After reset an IV_Load SHALL be required before any data is accepted.

Structure
REQ-033 SHALL take the state enumeration and the AES block-width constant (128) from the shared package aes_pkg.
REQ-034 SHALL put the 128-bit incrementer in one sub-module, ctr_inc128, which SHALL be combinational and have a carry-out.

Verification
REQ-035 Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data 6bc1bee22e409f96e93d7e117393172a -> Data_Out 601ec313775789a5b7a7f504bbf3d228, Block_Count=1.
REQ-036 A second block ae2d8a571e03ac9c9eb76fac45af8e51 with no reload -> Enc_Block f0f1f2f3f4f5f6f7f8f9fafbfcfdff00 and Data_Out f443e3ca4d62b59aca84e990cacaf5c5.
REQ-037 IV ffffffffffffffffffffffffffffffff, one block -> next Enc_Block 00000000000000000000000000000000.
REQ-038 Out_Ready held low 10 cycles -> Out_Valid and Data_Out stable, Data_Ready=0 and no Enc_Start throughout.
REQ-039 RST asserted mid-WAIT -> all outputs at reset values immediately; data offered before IV_Load -> Data_Ready stays 0.
REQ-040 IV_Load pulsed during WAIT -> ignored, with the counter advancing from the original IV.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES counter-mode sequencing block.
// Carries the block width and the controller state encoding.
package aes_pkg;

  localparam int AES_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUTPUT = 3'd4
  } ctr_state_t;

endpackage

// File: rtl/ctr_inc128.sv
// Combinational 128-bit unsigned incrementer with carry-out.
// All-ones wraps to zero and raises carry.
module ctr_inc128
  import aes_pkg::*;
(
  input  logic [AES_W-1:0] value,
  output logic [AES_W-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, value} + {{AES_W{1'b0}}, 1'b1};

endmodule

// File: rtl/aes_ctr_controller.sv
// Counter-mode sequencer: issues counter blocks to an AES core and XORs the
// returned keystream with the accepted data block.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no IV loaded since reset; data is never accepted
// ST_READY  | IV loaded; accepts data when Key_Valid is high
// ST_START  | one-cycle Enc_Start pulse with the counter block on Enc_Block
// ST_WAIT   | waiting for a fresh rising edge of Enc_Fin from the core
// ST_OUTPUT | Data_Out held valid until Out_Ready
module aes_ctr_controller
  import aes_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [AES_W-1:0]   IV_In,
  input  logic               IV_Load,
  input  logic               Key_Valid,
  input  logic [AES_W-1:0]   Data_In,
  input  logic               Data_Valid,
  output logic               Data_Ready,
  output logic [AES_W-1:0]   Enc_Block,
  output logic               Enc_Start,
  input  logic               Enc_Fin,
  input  logic [AES_W-1:0]   Keystream_In,
  output logic [AES_W-1:0]   Data_Out,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [CNT_W-1:0]   Block_Count,
  output logic               Busy
);

  ctr_state_t       state, state_nxt;
  logic [AES_W-1:0] ctr_reg, ctr_inc, data_reg, dout_reg;
  logic [CNT_W-1:0] blk_cnt;
  logic             fin_q;
  logic             unused_carry;
  logic             iv_load_ok, accept, complete;

  ctr_inc128 u_inc (
    .value (ctr_reg),
    .sum   (ctr_inc),
    .carry (unused_carry)
  );

  assign iv_load_ok = IV_Load && ((state == ST_IDLE) || (state == ST_READY));
  assign accept     = Data_Valid && Data_Ready;
  // Only a rise seen inside WAIT counts; a level still high from before is stale.
  assign complete   = (state == ST_WAIT) && Enc_Fin && !fin_q;

  assign Data_Ready  = (state == ST_READY) && Key_Valid;
  assign Enc_Start   = (state == ST_START);
  assign Out_Valid   = (state == ST_OUTPUT);
  assign Busy        = (state != ST_IDLE) && (state != ST_READY);
  assign Enc_Block   = ctr_reg;
  assign Data_Out    = dout_reg;
  assign Block_Count = blk_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (IV_Load)   state_nxt = ST_READY;
      ST_READY:  if (accept)    state_nxt = ST_START;
      ST_START:                 state_nxt = ST_WAIT;
      ST_WAIT:   if (complete)  state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (Out_Ready) state_nxt = ST_READY;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctr_reg  <= '0;
      data_reg <= '0;
      dout_reg <= '0;
      blk_cnt  <= '0;
      fin_q    <= 1'b0;
    end else begin
      fin_q <= Enc_Fin;
      if (iv_load_ok) begin
        ctr_reg <= IV_In;
        blk_cnt <= '0;
      end else if (complete) begin
        ctr_reg <= ctr_inc;
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
      if (accept) data_reg <= Data_In;
      if (complete) dout_reg <= data_reg ^ Keystream_In;
    end
  end

endmodule
